// File: rtl/accel_mac_top_if.sv
// Register-bus bundle for the MAC accelerator: address/write-data/write-enable in, read data and status out.
// Latency: none, wires only.
// Backpressure: none; writes are accepted on every clock edge where i_RF_WE is high.
interface accel_mac_top_if #(
    parameter int N              = 32,
    parameter int RF_Addr_BITNES = 6
);
    logic [RF_Addr_BITNES-1:0] i_addr;
    logic [N-1:0]              i_data;
    logic                      i_RF_WE;
    logic [N-1:0]              o_data;
    logic                      o_busy;
    logic                      o_done;

    // Bus host: drives address/data/enable and observes read data and flags.
    modport master (
        output i_addr, i_data, i_RF_WE,
        input  o_data, o_busy, o_done
    );

    // Accelerator side of the bus.
    modport slave (
        input  i_addr, i_data, i_RF_WE,
        output o_data, o_busy, o_done
    );
endinterface

// File: rtl/accel_mac_top.sv
// Register-mapped multiply-accumulate engine: sums A[i]*B[i] for i < LEN into a 2N-bit accumulator.
// Latency: LEN cycles in RUN after the start edge, then one DONE cycle; reads are combinational.
// Backpressure: none; writes to LEN/A/B/CTRL outside IDLE are dropped and flagged in wr_err. Option: ACC_SATURATE_EN.
module accel_mac_top #(
    parameter int N              = 32,
    parameter int RF_Addr_BITNES = 6,
    parameter int DEPTH          = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    accel_mac_top_if.slave      bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW = RF_Addr_BITNES;

    localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
    localparam logic [AW-1:0] ADDR_LEN    = AW'(1);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(2);
    localparam logic [AW-1:0] ADDR_RES_LO = AW'(3);
    localparam logic [AW-1:0] ADDR_RES_HI = AW'(4);
    localparam logic [AW-1:0] ADDR_A_BASE = AW'(16);
    localparam logic [AW-1:0] ADDR_A_END  = AW'(16 + DEPTH);
    localparam logic [AW-1:0] ADDR_B_BASE = AW'(32);
    localparam logic [AW-1:0] ADDR_B_END  = AW'(32 + DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic [N-1:0]       a_mem [DEPTH];
    logic [N-1:0]       b_mem [DEPTH];
    logic [LW-1:0]      len_q;
    logic [IW-1:0]      idx_q;
    logic [2*N-1:0]     acc_q;
    logic               ovf_q;
    logic               wr_err_q;
    logic               done_q;

    logic               a_hit;
    logic               b_hit;
    logic [IW-1:0]      wr_idx;
    logic               ctrl_wr;
    logic               prot_wr;
    logic               start;
    logic               last;
    logic [LW-1:0]      len_wr;
    logic [2*N-1:0]     prod;
    logic [2*N:0]       sum;
    logic [2*N-1:0]     acc_nxt;
    logic [N-1:0]       rdata;

    // Address decode, start detection and the accumulate step; both array bases are 16-aligned so the low address bits are the index.
    always_comb begin
        a_hit   = (bus.i_addr >= ADDR_A_BASE) && (bus.i_addr < ADDR_A_END);
        b_hit   = (bus.i_addr >= ADDR_B_BASE) && (bus.i_addr < ADDR_B_END);
        wr_idx  = bus.i_addr[IW-1:0];
        ctrl_wr = bus.i_RF_WE && (bus.i_addr == ADDR_CTRL);
        prot_wr = bus.i_RF_WE && ((bus.i_addr == ADDR_CTRL) || (bus.i_addr == ADDR_LEN) || a_hit || b_hit);
        start   = (state_q == S_IDLE) && ctrl_wr && bus.i_data[0];
        last    = ((LW'(idx_q) + LW'(1)) == len_q);
        len_wr  = (bus.i_data > N'(DEPTH)) ? LW'(DEPTH) : bus.i_data[LW-1:0];
        prod    = (2*N)'(a_mem[idx_q]) * (2*N)'(b_mem[idx_q]);
        sum     = {1'b0, acc_q} + {1'b0, prod};
`ifdef ACC_SATURATE_EN
        acc_nxt = sum[2*N] ? {(2*N){1'b1}} : sum[2*N-1:0];
`else
        acc_nxt = sum[2*N-1:0];
`endif
    end

    // State register; reset aborts any run without reaching DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: an empty job goes straight to DONE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len_q != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Register file, accumulator and sticky flags; operands are only writable while idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
            len_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            wr_err_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q    <= '0;
                        acc_q    <= '0;
                        ovf_q    <= 1'b0;
                        wr_err_q <= 1'b0;
                        done_q   <= 1'b0;
                    end else if (bus.i_RF_WE) begin
                        if (bus.i_addr == ADDR_LEN) begin
                            len_q <= len_wr;
                        end
                        if (a_hit) begin
                            a_mem[wr_idx] <= bus.i_data;
                        end
                        if (b_hit) begin
                            b_mem[wr_idx] <= bus.i_data;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_nxt;
                    if (sum[2*N]) begin
                        ovf_q <= 1'b1;
                    end
                    if (!last) begin
                        idx_q <= idx_q + IW'(1);
                    end
                    if (prot_wr) begin
                        wr_err_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    if (prot_wr) begin
                        wr_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational read mux; CTRL, out-of-depth array slots and holes read as zero.
    always_comb begin
        rdata = '0;
        if (bus.i_addr == ADDR_LEN) begin
            rdata = N'(len_q);
        end else if (bus.i_addr == ADDR_STATUS) begin
            rdata = N'({wr_err_q, ovf_q, done_q, (state_q == S_RUN)});
        end else if (bus.i_addr == ADDR_RES_LO) begin
            rdata = acc_q[N-1:0];
        end else if (bus.i_addr == ADDR_RES_HI) begin
            rdata = acc_q[2*N-1:N];
        end else if (a_hit) begin
            rdata = a_mem[wr_idx];
        end else if (b_hit) begin
            rdata = b_mem[wr_idx];
        end
    end

    assign bus.o_data = rdata;
    assign bus.o_busy = (state_q == S_RUN);
    assign bus.o_done = done_q;
endmodule

// File: tb/tb_accel_mac_top.sv
// Randomized bench for accel_mac_top against an exact-arithmetic reference of the register map and dot product.
// Latency: inputs change on the falling edge, outputs are sampled before the next rising edge.
// Backpressure: none; waits on busy/done are cycle-bounded.
module tb_accel_mac_top;
    localparam int N     = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [N-1:0] ma [DEPTH];
    logic [N-1:0] mb [DEPTH];
    int           mlen;

    always #5 clk = ~clk;

    accel_mac_top_if #(.N(N), .RF_Addr_BITNES(AW)) bus ();

    accel_mac_top #(.N(N), .RF_Addr_BITNES(AW), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic wr(input int addr, input logic [N-1:0] d);
        bus.i_addr  = AW'(addr);
        bus.i_data  = d;
        bus.i_RF_WE = 1'b1;
        @(negedge clk);
        bus.i_RF_WE = 1'b0;
    endtask

    task automatic rd(input int addr, output logic [N-1:0] d);
        bus.i_addr = AW'(addr);
        #2;
        d = bus.o_data;
        @(negedge clk);
    endtask

    // Write while idle and mirror the effect in the reference registers.
    task automatic mwr(input int addr, input logic [N-1:0] d);
        wr(addr, d);
        if (addr == 1) mlen = (d > DEPTH) ? DEPTH : int'(d);
        else if (addr >= 16 && addr < 16 + DEPTH) ma[addr-16] = d;
        else if (addr >= 32 && addr < 32 + DEPTH) mb[addr-32] = d;
    endtask

    // Start a job, optionally poke protected registers mid-run, and compare everything against the exact sum.
    task automatic start_run(input string tag, input bit poke, input bit exp_werr);
        logic [127:0] tot;
        logic [63:0]  exp_acc;
        logic         exp_ovf;
        logic [N-1:0] lo, hi, st;
        int           n;
        tot = '0;
        for (int i = 0; i < mlen; i++) tot += 128'(ma[i]) * 128'(mb[i]);
        exp_ovf = (tot[127:64] != '0);
        exp_acc = tot[63:0];
`ifdef ACC_SATURATE_EN
        if (exp_ovf) exp_acc = '1;
`endif
        wr(0, 1);
        n = 0;
        if (poke) begin
            wr(16, 99);
            wr(1, 1);
            n = 2;
        end
        while (bus.o_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(mlen));
        check({tag, "_done_cleared"}, 64'(bus.o_done), 64'd0);
        @(negedge clk);
        check({tag, "_done"}, 64'(bus.o_done), 64'd1);
        rd(3, lo);
        rd(4, hi);
        rd(2, st);
        check({tag, "_result"}, {hi, lo}, exp_acc);
        check({tag, "_status"}, 64'(st), 64'({exp_werr, exp_ovf, 1'b1, 1'b0}));
    endtask

    initial begin
        logic [N-1:0] v;
        rst         = 1'b1;
        bus.i_addr  = '0;
        bus.i_data  = '0;
        bus.i_RF_WE = 1'b0;
        mlen        = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        rd(2, v); check("rst_status", 64'(v), 64'd0);
        rd(1, v); check("rst_len", 64'(v), 64'd0);

        // Reference dot product: 1*5+2*6+3*7+4*8 = 70.
        for (int i = 0; i < 4; i++) begin
            mwr(16 + i, N'(i + 1));
            mwr(32 + i, N'(i + 5));
        end
        mwr(1, 4);
        start_run("basic", 1'b0, 1'b0);
        rd(3, v); check("basic_lo70", 64'(v), 64'd70);
        rd(18, v); check("readback_a2", 64'(v), 64'd3);
        rd(0, v); check("ctrl_reads0", 64'(v), 64'd0);
        rd(5, v); check("hole_reads0", 64'(v), 64'd0);
        rd(50, v); check("high_reads0", 64'(v), 64'd0);
        wr(3, 32'h1234); rd(3, v); check("ro_result_kept", 64'(v), 64'd70);

        // Start with bit0 clear does nothing; done stays sticky.
        wr(0, 32'h2);
        check("nostart_busy", 64'(bus.o_busy), 64'd0);
        check("nostart_done", 64'(bus.o_done), 64'd1);

        mwr(1, 0);
        start_run("len0", 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) begin
            mwr(16 + i, 32'hFFFF_FFFF);
            mwr(32 + i, 32'hFFFF_FFFF);
        end
        mwr(1, 2);
        start_run("ovf", 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            mwr(16 + i, N'(i + 1));
            mwr(32 + i, N'(i + 5));
        end
        mwr(1, 4);
        start_run("busy_write", 1'b1, 1'b1);
        rd(16, v); check("a0_unmodified", 64'(v), 64'd1);
        rd(1, v); check("len_unmodified", 64'(v), 64'd4);
        start_run("werr_clear", 1'b0, 1'b0);

        mwr(1, 20);
        rd(1, v); check("len_clamp", 64'(v), 64'd16);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mwr(16 + i, ($urandom_range(3) == 0) ? (32'hFFFF_0000 | $urandom) : $urandom);
                mwr(32 + i, ($urandom_range(3) == 0) ? (32'hFFFF_0000 | $urandom) : $urandom_range(4095));
            end
            mwr(1, $urandom_range(20));
            rd(1, v); check($sformatf("rand%0d_len", t), 64'(v), 64'(mlen));
            start_run($sformatf("rand%0d", t), 1'b0, 1'b0);
        end

        // Abort a long run with reset: nothing may survive.
        mwr(16, 7);
        mwr(47, 9);
        mwr(1, 16);
        wr(0, 1);
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(bus.o_busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_done", 64'(bus.o_done), 64'd0);
        rst = 1'b0;
        rd(1, v); check("abort_len", 64'(v), 64'd0);
        rd(2, v); check("abort_status", 64'(v), 64'd0);
        rd(3, v); check("abort_lo", 64'(v), 64'd0);
        rd(4, v); check("abort_hi", 64'(v), 64'd0);
        rd(16, v); check("abort_a0", 64'(v), 64'd0);
        rd(47, v); check("abort_b15", 64'(v), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/accel_mac_top.md
ACCEL_MAC_TOP -- requirements
Module: accel_mac_top

Interface
REQ-001 SHALL have parameter N, default 32: operand and bus data width.
REQ-002 SHALL have parameter RF_Addr_BITNES, default 6, minimum 6: register file address width.
REQ-003 SHALL have parameter DEPTH, default 16, power of two, 1..16: operand pairs held.
REQ-004 SHALL have port i_clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port i_addr  input  RF_Addr_BITNES: register word address.
REQ-007 SHALL have port i_data  input  N: write data.
REQ-008 SHALL have port i_RF_WE  input  1: write enable, sampled at i_clk rising edge.
REQ-009 SHALL have port o_data  output  N: read data, combinational from i_addr.
REQ-010 SHALL have port o_busy  output  1: computation in progress.
REQ-011 SHALL have port o_done  output  1: sticky completion flag.

Function
REQ-012 SHALL decode this map: 0 CTRL (write-only, bit0 start); 1 LEN (R/W); 2 STATUS (RO: bit0 busy, bit1 done, bit2 ovf, bit3 wr_err); 3 RESULT_LO (RO); 4 RESULT_HI (RO); 16..16+DEPTH-1 A[i]; 32..32+DEPTH-1 B[i].
REQ-013 SHALL return 0 on o_data for unmapped addresses, CTRL, and A/B indices >= DEPTH; SHALL ignore writes to RO/unmapped addresses.
REQ-014 SHALL store LEN in $clog2(DEPTH)+1 bits; written values > DEPTH SHALL be stored as DEPTH.
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 IDLE: a write to CTRL with bit0=1 SHALL on that edge clear accumulator, index, ovf, wr_err, done, and enter RUN (LEN>0) or DONE (LEN=0).
REQ-017 RUN: each cycle SHALL add unsigned A[idx]*B[idx] (2N-bit product) into a 2N-bit accumulator and increment idx; after LEN cycles SHALL enter DONE.
REQ-018 o_busy SHALL be 1 exactly while in RUN (LEN cycles, starting cycle after start edge).
REQ-019 DONE: lasts one cycle, sets done sticky, returns to IDLE; o_done SHALL stay 1 until the next accepted start or reset.
REQ-020 RESULT_LO/HI SHALL be accumulator bits [N-1:0] / [2N-1:N], readable any time.
REQ-021 Carry out of 2N-bit accumulator SHALL set sticky ovf.
REQ-022 Writes to LEN, A, B, or CTRL while state != IDLE SHALL be ignored and set sticky wr_err.
REQ-023 Start with bit0=0 SHALL have no effect; idx SHALL never exceed DEPTH-1.

Reset
REQ-024 i_reset SHALL, on the clock edge, force IDLE, clear A, B, LEN, accumulator, idx, ovf, wr_err, done; o_busy=0, o_done=0.
REQ-025 Reset SHALL take priority over simultaneous i_RF_WE and over an in-progress RUN (aborted, no partial done).

Configuration
REQ-026 Macro ACC_SATURATE_EN: when defined, accumulator SHALL clamp to all-ones on carry out (and stay there for remaining terms); ovf still set.
REQ-027 Without ACC_SATURATE_EN, accumulator SHALL wrap modulo 2^(2N).

Verification
REQ-028 N=32: A=[1,2,3,4], B=[5,6,7,8], LEN=4, start -> o_busy high 4 cycles, o_done=1, RESULT_LO=70, RESULT_HI=0, STATUS=0x2.
REQ-029 LEN=0, start -> o_busy never high, o_done=1 two edges after start, RESULT_LO=0.
REQ-030 A[0]=A[1]=B[0]=B[1]=0xFFFFFFFF, LEN=2, start -> ovf=1; default HI=0xFFFFFFFC LO=0x00000002; with ACC_SATURATE_EN HI=LO=0xFFFFFFFF.
REQ-031 During RUN write A[0]=99 and LEN=1 -> ignored, wr_err=1, result as if unmodified; next start clears wr_err.
REQ-032 Write LEN=20 -> LEN reads 16; reset asserted mid-RUN -> next cycle o_busy=0, o_done=0, all registers read 0.
